// File: rtl/result_display_pkg.sv
// result_display_pkg: shared types and constants for the result display.
// Holds the FSM state enum, display geometry and active-low segment codes.
package result_display_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    localparam int NUM_POS    = 6;
    localparam int NUM_DIGITS = 5;

    // Segment order {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    localparam logic [6:0] SEG_D0 = 7'b1000000;
    localparam logic [6:0] SEG_D1 = 7'b1111001;
    localparam logic [6:0] SEG_D2 = 7'b0100100;
    localparam logic [6:0] SEG_D3 = 7'b0110000;
    localparam logic [6:0] SEG_D4 = 7'b0011001;
    localparam logic [6:0] SEG_D5 = 7'b0010010;
    localparam logic [6:0] SEG_D6 = 7'b0000010;
    localparam logic [6:0] SEG_D7 = 7'b1111000;
    localparam logic [6:0] SEG_D8 = 7'b0000000;
    localparam logic [6:0] SEG_D9 = 7'b0010000;

endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder: 4-bit digit to active-low seven-segment pattern.
// Ports: i_digit (0..15), o_seg {g,f,e,d,c,b,a}; codes 10..15 are blank.
module seg7_decoder
    import result_display_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_digit)
            4'd0:    o_seg = SEG_D0;
            4'd1:    o_seg = SEG_D1;
            4'd2:    o_seg = SEG_D2;
            4'd3:    o_seg = SEG_D3;
            4'd4:    o_seg = SEG_D4;
            4'd5:    o_seg = SEG_D5;
            4'd6:    o_seg = SEG_D6;
            4'd7:    o_seg = SEG_D7;
            4'd8:    o_seg = SEG_D8;
            4'd9:    o_seg = SEG_D9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/result_display.sv
// result_display: captures the ALU result, converts it to BCD by
// sequential double-dabble and scans it onto a 6-position 7-seg display.
// Ports: clk, rst (async high), load/neg/result in; bcd, sign, busy,
// done, an (active-low position enables), seg (active-low segments) out.
module result_display
    import result_display_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        neg,
    input  logic [15:0] result,
    output logic [19:0] bcd,
    output logic        sign,
    output logic        busy,
    output logic        done,
    output logic [5:0]  an,
    output logic [6:0]  seg
);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_shift;
    logic [19:0] r_work;
    logic [3:0]  r_cnt;
    logic        r_pend;
    logic [19:0] r_bcd;
    logic        r_sign;
    logic        r_done;
    logic [15:0] r_presc;
    logic [2:0]  r_idx;

    logic [19:0] w_adj;
    logic [19:0] w_work_nxt;
    logic        w_last;
    logic [3:0]  w_digit;
    logic        w_blank;
    logic [6:0]  w_dec;

    // Add-3 correction happens before the shift so no nibble exceeds 9
    always_comb begin
        w_adj = r_work;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_work[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_work[4*i +: 4] + 4'd3;
        end
    end

    assign w_work_nxt = {w_adj[18:0], r_shift[15]};
    assign w_last     = (r_cnt == 4'd15);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (load)   w_next = ST_SHIFT;
            ST_SHIFT: if (w_last) w_next = ST_IDLE;
            default:              w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_work  <= '0;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
            r_bcd   <= '0;
            r_sign  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (load) begin
                        r_shift <= result;
                        r_pend  <= neg;
                        r_work  <= '0;
                        r_cnt   <= '0;
                    end
                end
                ST_SHIFT: begin
                    r_work  <= w_work_nxt;
                    r_shift <= {r_shift[14:0], 1'b0};
                    r_cnt   <= r_cnt + 4'd1;
                    // Final iteration publishes straight from the shifter
                    if (w_last) begin
                        r_bcd  <= w_work_nxt;
                        r_sign <= r_pend;
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Free-running scan, independent of the converter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (r_presc == 16'(SCAN_DIV - 1)) begin
            r_presc <= '0;
            if (r_idx == 3'(NUM_POS - 1)) r_idx <= '0;
            else                          r_idx <= r_idx + 3'd1;
        end else begin
            r_presc <= r_presc + 16'd1;
        end
    end

    // A digit blanks when it and every higher digit are zero
    always_comb begin
        w_digit = r_bcd[3:0];
        w_blank = 1'b0;
        case (r_idx)
            3'd0: w_digit = r_bcd[3:0];
            3'd1: begin
                w_digit = r_bcd[7:4];
                w_blank = (r_bcd[19:4] == 16'd0);
            end
            3'd2: begin
                w_digit = r_bcd[11:8];
                w_blank = (r_bcd[19:8] == 12'd0);
            end
            3'd3: begin
                w_digit = r_bcd[15:12];
                w_blank = (r_bcd[19:12] == 8'd0);
            end
            3'd4: begin
                w_digit = r_bcd[19:16];
                w_blank = (r_bcd[19:16] == 4'd0);
            end
            default: w_blank = 1'b1;
        endcase
    end

    seg7_decoder u_dec (
        .i_digit (w_digit),
        .o_seg   (w_dec)
    );

    always_comb begin
        seg = w_dec;
        if (r_idx == 3'(NUM_POS - 1))
            seg = r_sign ? SEG_MINUS : SEG_BLANK;
        else if (w_blank)
            seg = SEG_BLANK;
    end

    assign an   = ~(6'b000001 << r_idx);
    assign bcd  = r_bcd;
    assign sign = r_sign;
    assign busy = (r_state == ST_SHIFT);
    assign done = r_done;

endmodule

// File: doc/result_display.md
# result_display

Output stage of the calculator, downstream of the ALU. On a load strobe it captures the ALU's 16-bit magnitude `result` and its `neg` flag, converts the magnitude to five BCD digits with a sequential double-dabble (one iteration per clock), and holds the converted value. It also time-multiplexes the value onto a 6-position seven-segment display: position 5 is the sign, positions 4..0 are the digits, with leading-zero blanking.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each display position stays active; legal range 2..65535.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high. TOP drives it from `~nrst`.
- `load`  in  1  capture strobe for `result`/`neg`; honoured only in IDLE.
- `neg`  in  1  sign of the ALU result; 1 = negative.
- `result`  in  16  unsigned magnitude of the ALU result, 0..65535.
- `bcd`  out  20  converted digits; [19:16] = ten-thousands … [3:0] = units.
- `sign`  out  1  captured `neg` of the last completed conversion.
- `busy`  out  1  high while a conversion is in progress.
- `done`  out  1  one-cycle pulse when `bcd`/`sign` update.
- `an`  out  6  position enables, active-low; bit i = position i.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.

## Operation
- FSM states: IDLE, SHIFT.
  - In IDLE with `load`=1: capture `result` into a 16-bit shift register and `neg` into a pending-sign register. Clear the 20-bit working BCD register and the 4-bit iteration count. Go to SHIFT. Set `busy`=1.
  - In SHIFT, each cycle:
    - Every working BCD nibble ≥5 gets +3.
    - Then {working BCD, shift register} shifts left by 1.
    - The count increments.
  - After the 16th iteration: `bcd` = working value, `sign` = pending sign, `done`=1 for one cycle, `busy`=0, and the FSM returns to IDLE.
- `load` in SHIFT is ignored (not queued). `load` while in IDLE, including the cycle right after `done`, is accepted.
- Nibble arithmetic: the +3 correction is applied before the shift. No nibble exceeds 9 after the shift. Input 65535 must yield 20'h65535.
- `bcd` and `sign` change only on `done`. The display never shows partial conversions.
- Scan:
  - A prescaler counts 0..SCAN_DIV-1.
  - On wrap, the position index advances 0→1→…→5→0.
  - `an` is one-hot-low at the current index.
- Segment content:
  - Position 5: `seg`=7'b0111111 ('-') if `sign`, else 7'b1111111 (blank).
  - Positions 4..1: blank if that digit and all higher digits are 0; otherwise the decoded digit.
  - Position 0: always the decoded digit.
- `seg` and `an` are combinational from registered index and registered `bcd`/`sign`.

## Timing
- Reset values:
  - state IDLE, `busy`=0, `done`=0, `bcd`=0, `sign`=0.
  - Prescaler 0, index 0, hence `an`=6'b111110 and `seg`=7'b1000000 ('0').
- Latency: `load` sampled at edge k, so `busy`=1 from edge k. Iterations occur at edges k+1..k+16. `done`=1, `busy`=0 and outputs update at edge k+16. `done` drops at k+17.
- Back-to-back throughput: one conversion per 17 cycles.
- `rst` mid-conversion: everything returns to reset values immediately. No `done` is produced for the aborted conversion.
- Scan is free-running and independent of the FSM. `an` changes exactly every SCAN_DIV cycles.

## Structure
- Package `result_display_pkg`:
  - state enum.
  - segment constants SEG_BLANK, SEG_MINUS.
  - digit-to-segment constants for 0–9.
  - NUM_POS=6, NUM_DIGITS=5.
- Sub-module `seg7_decoder`: combinational 4-bit digit to 7-bit active-low segments. Codes 10–15 give blank.
- Top of block: FSM/double-dabble datapath, prescaler/scan counter, blanking mux.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle. Required: `busy`=0, `done`=0, `bcd`=0, `sign`=0, `an`=6'b111110, `seg`=7'b1000000, all without waiting for a clock edge.
- Max value: `load` with `result`=16'd65025, `neg`=0. Required: `busy` high for exactly 16 cycles, `done` pulse at edge k+16, `bcd`=20'h65025, `sign`=0. Repeat with 65535, which must give 20'h65535.
- Negative with blanking, SCAN_DIV=4: `result`=16'd255, `neg`=1. Required: `bcd`=20'h00255, `sign`=1. Over 24 cycles, `an` steps 0..5 every 4 cycles and wraps. Segments by position: pos0 '5', pos1 '5', pos2 '2', pos3 blank, pos4 blank, pos5 7'b0111111.
- Zero: `result`=0, `neg`=0. Required: `bcd`=0, with pos0 showing '0' and pos1..5 blank.
- Load collision: first `load` with 100. Second `load` with 200 at edge k+5, which must be ignored, giving `bcd`=20'h00100. Then `load` with 200 at edge k+17, which must be accepted, giving `done` at k+33 and `bcd`=20'h00200.
- Reset mid-conversion: `load` 12345, then `rst` at cycle k+8. Required: no `done`, `bcd` stays 0. A fresh `load` afterwards converts correctly to 20'h12345.
